// File: rtl/vector_pkg.sv
// Shared widths, state encoding and the error cause code for the vector responder.
// Pure definitions; no logic, no latency, no flow control.
package vector_pkg;
    localparam int          DATA_W_DEF = 23;
    localparam int          SPEC_W     = 4;
    localparam int          DEPTH_DEF  = 4;
    localparam logic [3:0]  ERR_CODE   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;
endpackage

// File: rtl/vector_responder_if.sv
// FSM-side interrupt handshake plus local pop port of the vector responder.
// Wiring only; the master is the FSM/consumer side, the slave is the responder.
interface vector_responder_if #(
    parameter int DATA_W = vector_pkg::DATA_W_DEF,
    parameter int DEPTH  = vector_pkg::DEPTH_DEF
);
    localparam int SW = vector_pkg::SPEC_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 intr;
    logic [SW-1:0]        specreg;
    logic                 stop;
    logic [DATA_W-1:0]    data_in;
    logic                 rd_en;
    logic                 ack;
    logic                 ena;
    logic [DATA_W+SW-1:0] rd_data;
    logic                 rd_valid;
    logic [CW-1:0]        count;
    logic                 err;

    modport master (
        output intr, specreg, stop, data_in, rd_en,
        input  ack, ena, rd_data, rd_valid, count, err
    );

    modport slave (
        input  intr, specreg, stop, data_in, rd_en,
        output ack, ena, rd_data, rd_valid, count, err
    );
endinterface

// File: rtl/vector_fifo.sv
// Capture FIFO: write lands at the edge, pop data appears registered one cycle later.
// Writes beyond DEPTH and pops when empty are dropped; count_nxt exposes next occupancy.
module vector_fifo
    import vector_pkg::*;
#(
    parameter int  W     = DATA_W_DEF + SPEC_W,
    parameter int  DEPTH = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          wr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_req,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    // Fullness is judged on the pre-read count, so a full FIFO never accepts a write.
    assign do_wr = wr && (count < CW'(DEPTH));
    assign do_rd = rd_req && (count != '0);

    always_comb begin
        count_nxt = count;
        if (do_wr && !do_rd)
            count_nxt = count + CW'(1);
        else if (!do_wr && do_rd)
            count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            count    <= count_nxt;
            rd_valid <= do_rd;
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
        end
    end
endmodule

// File: rtl/vector_responder.sv
// Acknowledges FSM interrupts, capturing {specreg,data_in} into a FIFO the local consumer pops.
// ack one cycle after capture; backpressure by withholding ack/ena while the FIFO is full.
module vector_responder
    import vector_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               arst,
    vector_responder_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state;
    state_t        state_nxt;
    logic          wr;
    logic          ack_q;
    logic          ena_q;
    logic          err_q;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        if (bus.stop) begin
            state_nxt = HALT;
        end else begin
            unique case (state)
                IDLE: if (bus.intr && (count < CW'(DEPTH))) begin
                    wr        = 1'b1;
                    state_nxt = ACK;
                end
                ACK:  state_nxt = HOLD;
                HOLD: if (!bus.intr) state_nxt = IDLE;
                HALT: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state/next-count so they track the state exactly.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
            ack_q <= 1'b0;
            ena_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            ack_q <= (state_nxt == ACK);
            ena_q <= (state_nxt == IDLE) && (count_nxt < CW'(DEPTH));
            err_q <= err_q | (wr && (bus.specreg == ERR_CODE));
        end
    end

    vector_fifo #(
        .W     (DATA_W + SPEC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst      (arst),
        .wr        (wr),
        .wr_data   ({bus.specreg, bus.data_in}),
        .rd_req    (bus.rd_en),
        .rd_data   (bus.rd_data),
        .rd_valid  (bus.rd_valid),
        .count     (count),
        .count_nxt (count_nxt)
    );

    assign bus.ack   = ack_q;
    assign bus.ena   = ena_q;
    assign bus.err   = err_q;
    assign bus.count = count;
endmodule

// File: doc/vector_responder.md
VECTOR_RESPONDER -- requirements
Module: vector_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 23, the vector payload width.
REQ-002 SHALL have parameter DEPTH, default 4, the capture FIFO depth (power of two).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port arst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port intr, input, 1 bit: interrupt request from the vector FSM.
REQ-006 SHALL have port specreg, input, 4 bits: cause code accompanying intr.
REQ-007 SHALL have port stop, input, 1 bit: halt request from the vector FSM.
REQ-008 SHALL have port data_in, input, DATA_W bits: vector payload accompanying intr.
REQ-009 SHALL have port rd_en, input, 1 bit: local consumer pop request.
REQ-010 SHALL have port ack, output, 1 bit: interrupt acknowledge back to the FSM.
REQ-011 SHALL have port ena, output, 1 bit: enable to the FSM, high when the responder can accept.
REQ-012 SHALL have port rd_data, output, DATA_W+4 bits: popped entry {specreg, data}.
REQ-013 SHALL have port rd_valid, output, 1 bit: rd_data valid for one cycle.
REQ-014 SHALL have port count, output, log2(DEPTH)+1 bits: FIFO occupancy.
REQ-015 SHALL have port err, output, 1 bit: sticky; set when an entry with specreg = 4'hF is captured.

Function
REQ-016 SHALL implement FSM states IDLE, ACK, HOLD, HALT.
REQ-017 SHALL, in IDLE with intr=1 and count<DEPTH, write {specreg,data_in} into the FIFO at that edge and move to ACK.
REQ-018 SHALL, in IDLE with intr=1 and count=DEPTH, stay in IDLE, write nothing and withhold ack (backpressure).
REQ-019 SHALL drive ack=1 exactly while in ACK (one cycle), then move unconditionally to HOLD.
REQ-020 SHALL leave HOLD for IDLE on the first edge with intr=0; a still-high intr is never captured twice.
REQ-021 SHALL drive ena=1 in IDLE when count<DEPTH, else 0 (registered, no combinational path from inputs).
REQ-022 SHALL enter HALT from any state when stop=1; ack=0 and ena=0 in HALT; stop has priority over intr on the same edge.
REQ-023 SHALL leave HALT for IDLE on the first edge with stop=0; FIFO contents are kept.
REQ-024 SHALL, on rd_en=1 with count>0, present the oldest entry on rd_data with rd_valid=1 in the next cycle; otherwise rd_valid=0 and rd_data holds.
REQ-025 SHALL ignore rd_en when empty, with no underflow and no count change.
REQ-026 SHALL handle a simultaneous write and read in one cycle with count unchanged; fullness for REQ-018 is judged before the read.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH.
REQ-028 SHALL keep pops working in every FSM state, including HALT.

Reset
REQ-029 SHALL, on arst=1, immediately force state=IDLE, ack=0, ena=0, rd_data=0, rd_valid=0, count=0, err=0 and both pointers to 0, independent of clk.
REQ-030 SHALL, on arst during ACK, drop ack at once and discard all captured entries.
REQ-031 SHALL raise ena on the first clk edge after arst deasserts.

Structure
REQ-032 SHALL take DATA_W default, SPEC_W=4, DEPTH default, state encoding and the ERR_CODE=4'hF constant from shared package vector_pkg.
REQ-033 SHALL place the FIFO storage, pointers and count in sub-module vector_fifo, with the FSM in vector_responder.

Verification
REQ-034 SHALL test reset: arst=1 for 40 ns, then release -> all outputs 0 during reset and ena=1 one edge after release.
REQ-035 SHALL test single capture: intr=1, specreg=4'h3, data_in=15535 -> ack is a one-cycle pulse, count=1, and rd_en gives rd_data={4'h3,23'd15535} with rd_valid=1.
REQ-036 SHALL test overflow: 4 captures (data 1..4) with no reads, then a 5th intr -> no ack, ena=0; one pop returns 1, and the 5th is then acked and captured.
REQ-037 SHALL test halt: stop=1 coincident with intr -> HALT, no ack and no write; stop=0 -> IDLE, then intr is acked normally.
REQ-038 SHALL test error: capture with specreg=4'hF, data_in=55555 -> err=1 and stays 1 until arst.
REQ-039 SHALL test simultaneous access: count=2 with write and rd_en in the same cycle -> count stays 2 and the pops come out in FIFO order.
